// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered TX UART.
// BUFFERED_TX_UART_BREAK_EN adds the BREAK state to the FSM encoding.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef BUFFERED_TX_UART_BREAK_EN
      , ST_BREAK
`endif
   } tx_state_e;

   typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
   typedef enum logic       {ORD_LSB, ORD_MSB} order_e;

   // Bit period in clock cycles, rounded to the nearest integer.
   function automatic int calc_factor(input int clock, input int baud);
      return (clock + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/buffered_tx_uart_if.sv
// Producer-side bus of the buffered TX UART: write port, FIFO status and line.
// The brk request only exists when BUFFERED_TX_UART_BREAK_EN is defined.
interface buffered_tx_uart_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
`ifdef BUFFERED_TX_UART_BREAK_EN
   logic                 brk;
`endif
   logic                 full;
   logic [LW-1:0]        level;
   logic                 overflow;
   logic                 txd;
   logic                 busy;

   modport master (
`ifdef BUFFERED_TX_UART_BREAK_EN
      output brk,
`endif
      output wr_en, wr_data,
      input  full, level, overflow, txd, busy
   );

   modport slave (
`ifdef BUFFERED_TX_UART_BREAK_EN
      input  brk,
`endif
      input  wr_en, wr_data,
      output full, level, overflow, txd, busy
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// A write while full is dropped unless a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_wr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_rd,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [LW-1:0]    r_count;
   logic             w_push, w_pop;

   assign w_pop      = i_rd && !o_empty;
   assign w_push     = i_wr && (!o_full || w_pop);
   assign o_overflow = i_wr && !w_push;
   assign o_full     = (r_count == LW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_level    = r_count;
   assign o_rdata    = r_mem[r_rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end
endmodule

// File: rtl/buffered_tx_uart.sv
// Parametrised UART transmitter fed by an internal FIFO; frames stream back to back.
// Define BUFFERED_TX_UART_BREAK_EN to add the brk input and the BREAK state.
module buffered_tx_uart
   import uart_pkg::*;
#(
   parameter int    CLOCK      = 10_000_000,
   parameter int    BAUD       = 1_000_000,
   parameter int    DATA_BITS  = 8,
   parameter string PARITY     = "NO",
   parameter string FIRST_BIT  = "LSB",
   parameter int    STOP_BITS  = 1,
   parameter int    FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   buffered_tx_uart_if.slave   bus
);
   localparam int      FACTOR     = calc_factor(CLOCK, BAUD);
   localparam parity_e PAR        = (PARITY == "ODD")  ? PAR_ODD :
                                    (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;
   localparam order_e  ORD        = (FIRST_BIT == "MSB") ? ORD_MSB : ORD_LSB;
   localparam int      FRAME_BITS = 1 + DATA_BITS + ((PAR != PAR_NONE) ? 1 : 0) + STOP_BITS;
   localparam int      CW         = $clog2(FACTOR);
   localparam int      BW         = 4;
   localparam bit      CFG_OK     = (FACTOR >= 2) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                                    (PARITY == "NO" || PARITY == "ODD" || PARITY == "EVEN") &&
                                    (FIRST_BIT == "LSB" || FIRST_BIT == "MSB") &&
                                    (STOP_BITS == 1 || STOP_BITS == 2) && (FIFO_DEPTH >= 2) &&
                                    ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

   if (!CFG_OK) begin : g_bad_cfg
      $error("buffered_tx_uart: illegal parameter set or bit period below 2 cycles");
   end

   tx_state_e            r_state, w_state_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [BW-1:0]        r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_par, w_par_nxt;
   logic                 r_txd, w_txd_nxt;
   logic                 w_tick, w_load, w_pop, w_empty;
   logic [DATA_BITS-1:0] w_rdata;

   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_wr       (bus.wr_en),
      .i_wdata    (bus.wr_data),
      .i_rd       (w_pop),
      .o_rdata    (w_rdata),
      .o_full     (bus.full),
      .o_empty    (w_empty),
      .o_level    (bus.level),
      .o_overflow (bus.overflow)
   );

   function automatic logic lead(input logic [DATA_BITS-1:0] v);
      return (ORD == ORD_MSB) ? v[DATA_BITS-1] : v[0];
   endfunction

   function automatic logic [DATA_BITS-1:0] advance(input logic [DATA_BITS-1:0] v);
      return (ORD == ORD_MSB) ? {v[DATA_BITS-2:0], 1'b0} : {1'b0, v[DATA_BITS-1:1]};
   endfunction

   assign w_tick   = (r_cnt == CW'(FACTOR - 1));
   assign bus.txd  = r_txd;
   assign bus.busy = (r_state != ST_IDLE) || !w_empty;

   // txd is registered from the next-state decode so each bit starts on the state change.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_tick ? '0 : r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_txd_nxt   = r_txd;
      w_load      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
`ifdef BUFFERED_TX_UART_BREAK_EN
            if (bus.brk) begin
               w_state_nxt = ST_BREAK;
               w_bit_nxt   = '0;
               w_txd_nxt   = 1'b0;
            end else
`endif
            if (!w_empty) w_load = 1'b1;
         end
         ST_START: if (w_tick) begin
            w_state_nxt = ST_DATA;
            w_bit_nxt   = '0;
            w_txd_nxt   = lead(r_shift);
         end
         ST_DATA: if (w_tick) begin
            w_shift_nxt = advance(r_shift);
            if (r_bit == BW'(DATA_BITS - 1)) begin
               w_bit_nxt = '0;
               if (PAR != PAR_NONE) begin
                  w_state_nxt = ST_PARITY;
                  w_txd_nxt   = r_par;
               end else begin
                  w_state_nxt = ST_STOP;
                  w_txd_nxt   = 1'b1;
               end
            end else begin
               w_bit_nxt = r_bit + 1'b1;
               w_txd_nxt = lead(advance(r_shift));
            end
         end
         ST_PARITY: if (w_tick) begin
            w_state_nxt = ST_STOP;
            w_bit_nxt   = '0;
            w_txd_nxt   = 1'b1;
         end
         ST_STOP: if (w_tick) begin
            if (r_bit == BW'(STOP_BITS - 1)) begin
`ifdef BUFFERED_TX_UART_BREAK_EN
               if (bus.brk) begin
                  w_state_nxt = ST_BREAK;
                  w_bit_nxt   = '0;
                  w_txd_nxt   = 1'b0;
               end else
`endif
               if (!w_empty) w_load = 1'b1;
               else begin
                  w_state_nxt = ST_IDLE;
                  w_txd_nxt   = 1'b1;
               end
            end else begin
               w_bit_nxt = r_bit + 1'b1;
            end
         end
`ifdef BUFFERED_TX_UART_BREAK_EN
         // Hold the line low for at least one frame, then one bit of mark via STOP.
         ST_BREAK: if (w_tick) begin
            if (r_bit != BW'(FRAME_BITS - 1)) w_bit_nxt = r_bit + 1'b1;
            else if (!bus.brk) begin
               w_state_nxt = ST_STOP;
               w_bit_nxt   = BW'(STOP_BITS - 1);
               w_txd_nxt   = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
      if (w_load) begin
         w_pop       = 1'b1;
         w_shift_nxt = w_rdata;
         w_par_nxt   = (^w_rdata) ^ (PAR == PAR_ODD);
         w_state_nxt = ST_START;
         w_txd_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_txd   <= w_txd_nxt;
      end
   end
endmodule
